// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU sequencer.
// Contents: opcode encodings, flag bit positions, sequencer state type,
// and the legal-opcode check used at accept time.
package vec_alu_pkg;

  localparam int unsigned OPW   = 3;
  localparam int unsigned FLAGW = 4;

  localparam logic [OPW-1:0] OP_MUL = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SET = 3'b111;

  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the four opcodes the lane ALUs implement.
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    logic legal;
    case (op)
      OP_MUL, OP_SUB, OP_ADD, OP_SET: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/vec_alu_sequencer_slicer.sv
// vec_beat_slicer: selects the LANES-wide operand window of one beat.
// Ports: en (zero all outputs when low), beat (beat index), vec_a/vec_b
// (full source vectors), lane_a/lane_b (per-lane operands), lane_idx
// (global element index per lane).
module vec_beat_slicer
  import vec_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned VLEN  = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned BEATS = 2,
  parameter int unsigned BW    = 1,
  parameter int unsigned IDXW  = 3
) (
  input  logic                    en,
  input  logic [BW-1:0]           beat,
  input  logic [VLEN*WIDTH-1:0]   vec_a,
  input  logic [VLEN*WIDTH-1:0]   vec_b,
  output logic [LANES*WIDTH-1:0]  lane_a,
  output logic [LANES*WIDTH-1:0]  lane_b,
  output logic [LANES*IDXW-1:0]   lane_idx
);

  localparam int unsigned SLW = LANES * WIDTH;

  // Constant-base window per beat keeps the mux shallow and lint-clean.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_idx = '0;
    if (en) begin
      for (int b = 0; b < int'(BEATS); b++) begin
        if (beat == BW'(b)) begin
          lane_a = vec_a[b*SLW +: SLW];
          lane_b = vec_b[b*SLW +: SLW];
          for (int j = 0; j < int'(LANES); j++) begin
            lane_idx[j*IDXW +: IDXW] = IDXW'(b * int'(LANES) + j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: runs one VLEN-element vector op over LANES lane ALUs.
// Ports: in_* request side (valid/ready, opcode, scalar flag, vectors,
// scalar c), abort, alu_* lane-array side (registered operands, combinational
// results/flags back), out_* result side (valid/ready, vector, OR of flags,
// illegal-opcode error).
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned VLEN  = 8,
  parameter  int unsigned LANES = 4,
  localparam int unsigned BEATS = VLEN / LANES,
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned IDXW  = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPW-1:0]          in_opcode,
  input  logic                    in_flag_scalar,
  input  logic [VLEN*WIDTH-1:0]   in_vec_a,
  input  logic [VLEN*WIDTH-1:0]   in_vec_b,
  input  logic [WIDTH-1:0]        in_scalar_c,
  input  logic                    abort,
  output logic                    alu_en,
  output logic [LANES*WIDTH-1:0]  alu_a,
  output logic [LANES*WIDTH-1:0]  alu_b,
  output logic [LANES*WIDTH-1:0]  alu_c,
  output logic [OPW-1:0]          alu_opcode,
  output logic                    alu_flag_scalar,
  output logic [LANES*IDXW-1:0]   alu_instance_num,
  input  logic [LANES*WIDTH-1:0]  alu_result,
  input  logic [LANES*FLAGW-1:0]  alu_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VLEN*WIDTH-1:0]   out_vec,
  output logic [FLAGW-1:0]        out_flags,
  output logic                    out_err
);

  localparam int unsigned VW  = VLEN * WIDTH;
  localparam int unsigned SLW = LANES * WIDTH;

  if ((VLEN % LANES) != 0) begin : g_bad_cfg
    $error("vec_alu_sequencer: VLEN must be a multiple of LANES");
  end

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [OPW-1:0]      op_q, op_d;
  logic                fs_q, fs_d;
  logic [WIDTH-1:0]    c_q, c_d;
  logic [VW-1:0]       vec_a_q, vec_a_d;
  logic [VW-1:0]       vec_b_q, vec_b_d;
  logic [VW-1:0]       out_vec_q, out_vec_d;
  logic [FLAGW-1:0]    out_flags_q, out_flags_d;
  logic                out_err_q, out_err_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                alu_en_q, alu_en_d;
  logic [SLW-1:0]      alu_a_q, alu_b_q, slice_a, slice_b;
  logic [LANES*IDXW-1:0] alu_idx_q, slice_idx;

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    op_d        = op_q;
    fs_d        = fs_q;
    c_d         = c_q;
    vec_a_d     = vec_a_q;
    vec_b_d     = vec_b_q;
    out_vec_d   = out_vec_q;
    out_flags_d = out_flags_q;
    out_err_d   = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d        = in_opcode;
          fs_d        = in_flag_scalar;
          c_d         = in_scalar_c;
          vec_a_d     = in_vec_a;
          vec_b_d     = in_vec_b;
          out_vec_d   = '0;
          out_flags_d = '0;
          out_err_d   = 1'b0;
          beat_d      = '0;
          if (is_legal_op(in_opcode)) begin
            state_d = ST_RUN;
          end else begin
            out_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          for (int b = 0; b < int'(BEATS); b++) begin
            if (beat_q == BW'(b)) begin
              out_vec_d[b*SLW +: SLW] = alu_result;
            end
          end
          for (int j = 0; j < int'(LANES); j++) begin
            out_flags_d[FLG_V] = out_flags_d[FLG_V] | alu_flags[j*FLAGW + FLG_V];
            out_flags_d[FLG_N] = out_flags_d[FLG_N] | alu_flags[j*FLAGW + FLG_N];
            out_flags_d[FLG_Z] = out_flags_d[FLG_Z] | alu_flags[j*FLAGW + FLG_Z];
            out_flags_d[FLG_C] = out_flags_d[FLG_C] | alu_flags[j*FLAGW + FLG_C];
          end
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = ST_DONE;
            beat_d  = '0;
          end else begin
            beat_d = BW'(beat_q + BW'(1));
          end
        end
      end
      ST_DONE: begin
        if (abort || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    alu_en_d    = (state_d == ST_RUN);
  end

  // Operands for the upcoming beat are looked up ahead so they can be registered.
  vec_beat_slicer #(
    .WIDTH (WIDTH),
    .VLEN  (VLEN),
    .LANES (LANES),
    .BEATS (BEATS),
    .BW    (BW),
    .IDXW  (IDXW)
  ) u_slicer (
    .en       (alu_en_d),
    .beat     (beat_d),
    .vec_a    (vec_a_d),
    .vec_b    (vec_b_d),
    .lane_a   (slice_a),
    .lane_b   (slice_b),
    .lane_idx (slice_idx)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      op_q        <= '0;
      fs_q        <= 1'b0;
      c_q         <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      out_vec_q   <= '0;
      out_flags_q <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      op_q        <= op_d;
      fs_q        <= fs_d;
      c_q         <= c_d;
      vec_a_q     <= vec_a_d;
      vec_b_q     <= vec_b_d;
      out_vec_q   <= out_vec_d;
      out_flags_q <= out_flags_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_en_q    <= alu_en_d;
      alu_a_q     <= slice_a;
      alu_b_q     <= slice_b;
      alu_idx_q   <= slice_idx;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_vec          = out_vec_q;
  assign out_flags        = out_flags_q;
  assign out_err          = out_err_q;
  assign alu_en           = alu_en_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_instance_num = alu_idx_q;
  assign alu_c            = {LANES{c_q}};
  assign alu_opcode       = op_q;
  assign alu_flag_scalar  = fs_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: lane ALUs emulated in the bench, a
// transaction-level model of the expected behaviour, a per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_vec_alu_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned VLEN  = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = VLEN / LANES;
  localparam int unsigned IDXW  = $clog2(VLEN);
  localparam int unsigned VW    = VLEN * WIDTH;
  localparam int unsigned LW    = LANES * WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_opcode;
  logic                  in_flag_scalar;
  logic [VW-1:0]         in_vec_a;
  logic [VW-1:0]         in_vec_b;
  logic [WIDTH-1:0]      in_scalar_c;
  logic                  abort;
  logic                  alu_en;
  logic [LW-1:0]         alu_a, alu_b, alu_c;
  logic [2:0]            alu_opcode;
  logic                  alu_flag_scalar;
  logic [LANES*IDXW-1:0] alu_instance_num;
  logic [LW-1:0]         alu_result;
  logic [LANES*4-1:0]    alu_flags;
  logic                  out_valid;
  logic                  out_ready;
  logic [VW-1:0]         out_vec;
  logic [3:0]            out_flags;
  logic                  out_err;

  int checks = 0;
  int errors = 0;

  vec_alu_sequencer #(.WIDTH(WIDTH), .VLEN(VLEN), .LANES(LANES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opcode        (in_opcode),
    .in_flag_scalar   (in_flag_scalar),
    .in_vec_a         (in_vec_a),
    .in_vec_b         (in_vec_b),
    .in_scalar_c      (in_scalar_c),
    .abort            (abort),
    .alu_en           (alu_en),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_c            (alu_c),
    .alu_opcode       (alu_opcode),
    .alu_flag_scalar  (alu_flag_scalar),
    .alu_instance_num (alu_instance_num),
    .alu_result       (alu_result),
    .alu_flags        (alu_flags),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_vec          (out_vec),
    .out_flags        (out_flags),
    .out_err          (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One element through a lane ALU: returns {V,N,Z,C, result}.
  function automatic logic [WIDTH+3:0] lane_fn(input logic [2:0] op, input logic fs,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0]   o, r;
    logic [2*WIDTH-1:0] p;
    logic               cy, v;
    o = fs ? c : b;
    cy = 1'b0; v = 1'b0; r = '0; p = '0;
    case (op)
      3'b000: begin p = a * o; r = p[WIDTH-1:0]; cy = |p[2*WIDTH-1:WIDTH]; v = cy; end
      3'b001: begin
        {cy, r} = {1'b0, a} - {1'b0, o};
        v = (a[WIDTH-1] != o[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: begin
        {cy, r} = {1'b0, a} + {1'b0, o};
        v = (a[WIDTH-1] == o[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b111: r = c;
      default: r = '0;
    endcase
    return {v, r[WIDTH-1], (r == '0), cy, r};
  endfunction

  function automatic logic legal_op(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b111);
  endfunction

  // Whole-vector expected result: {OR of flags, result vector}.
  function automatic logic [VW+3:0] vec_expect(input logic [2:0] op, input logic fs,
                                               input logic [VW-1:0] a, input logic [VW-1:0] b,
                                               input logic [WIDTH-1:0] c);
    logic [VW-1:0]    v;
    logic [3:0]       f;
    logic [WIDTH+3:0] e;
    v = '0; f = '0;
    if (legal_op(op)) begin
      for (int i = 0; i < int'(VLEN); i++) begin
        e = lane_fn(op, fs, a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH], c);
        v[i*WIDTH +: WIDTH] = e[WIDTH-1:0];
        f = f | e[WIDTH+3:WIDTH];
      end
    end
    return {f, v};
  endfunction

  // Emulated lane ALU array.
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      {alu_flags[j*4 +: 4], alu_result[j*WIDTH +: WIDTH]} =
        lane_fn(alu_opcode, alu_flag_scalar, alu_a[j*WIDTH +: WIDTH],
                alu_b[j*WIDTH +: WIDTH], alu_c[j*WIDTH +: WIDTH]);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: m_cnt counts cycles since accept (1 = first beat).
  bit            m_known = 1'b0;
  bit            m_active = 1'b0;
  bit            m_clear = 1'b0;
  int            m_cnt = 0;
  int            m_len = 0;
  logic [2:0]    m_op;
  logic          m_fs;
  logic [WIDTH-1:0] m_c;
  logic [VW-1:0] m_a, m_b, m_vec;
  logic [3:0]    m_flags;
  logic          m_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known  <= 1'b1;
      m_active <= 1'b0;
      m_clear  <= 1'b1;
      m_cnt    <= 0;
      m_len    <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_clear  <= 1'b0;
        m_cnt    <= 1;
        m_len    <= legal_op(in_opcode) ? int'(BEATS) : 0;
        m_err    <= !legal_op(in_opcode);
        m_op     <= in_opcode;
        m_fs     <= in_flag_scalar;
        m_c      <= in_scalar_c;
        m_a      <= in_vec_a;
        m_b      <= in_vec_b;
        {m_flags, m_vec} <= vec_expect(in_opcode, in_flag_scalar, in_vec_a, in_vec_b, in_scalar_c);
      end
    end else if (abort) begin
      m_active <= 1'b0;
    end else if (m_cnt <= m_len) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
    end
  end

  task automatic compare_cycle();
    logic [LW-1:0]         ea, eb;
    logic [LANES*IDXW-1:0] ei;
    bit                    exp_en, exp_valid;
    int                    k;
    exp_en    = m_active && (m_cnt <= m_len);
    exp_valid = m_active && (m_cnt > m_len);
    chk("in_ready", in_ready, !m_active);
    chk("alu_en", alu_en, exp_en);
    chk("out_valid", out_valid, exp_valid);
    ea = '0; eb = '0; ei = '0;
    if (exp_en) begin
      k = m_cnt - 1;
      for (int j = 0; j < int'(LANES); j++) begin
        ea[j*WIDTH +: WIDTH] = m_a[(k*int'(LANES)+j)*WIDTH +: WIDTH];
        eb[j*WIDTH +: WIDTH] = m_b[(k*int'(LANES)+j)*WIDTH +: WIDTH];
        ei[j*IDXW +: IDXW]   = IDXW'(k*int'(LANES)+j);
      end
      chk("alu_c", alu_c, {LANES{m_c}});
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_flag_scalar", alu_flag_scalar, m_fs);
    end
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_instance_num", alu_instance_num, ei);
    if (exp_valid) begin
      chk("out_vec", out_vec, m_vec);
      chk("out_flags", out_flags, m_flags);
      chk("out_err", out_err, m_err);
    end
    if (m_clear) begin
      chk("clr_out_vec", out_vec, '0);
      chk("clr_out_flags", out_flags, '0);
      chk("clr_out_err", out_err, 1'b0);
      chk("clr_alu_c", alu_c, '0);
      chk("clr_alu_opcode", alu_opcode, 3'b000);
      chk("clr_alu_flag", alu_flag_scalar, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (m_known) compare_cycle();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(VLEN); i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  // Present a request for one edge (DUT assumed idle), then scramble the inputs.
  task automatic issue(input logic [2:0] op, input logic fs, input logic [VW-1:0] a,
                       input logic [VW-1:0] b, input logic [WIDTH-1:0] c);
    in_valid = 1'b1; in_opcode = op; in_flag_scalar = fs;
    in_vec_a = a; in_vec_b = b; in_scalar_c = c;
    tick();
    in_valid = 1'b0;
    in_vec_a = rand_vec(); in_vec_b = rand_vec(); in_scalar_c = WIDTH'($urandom);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [VW-1:0] va, vb, ve;
  logic [2:0]    ops [8];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_flag_scalar = 1'b0;
    in_vec_a = '0; in_vec_b = '0; in_scalar_c = '0; abort = 1'b0; out_ready = 1'b0;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b111;
    ops[4] = 3'b011; ops[5] = 3'b100; ops[6] = 3'b101; ops[7] = 3'b110;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_out_vec", out_vec, '0);

    // Plain add, latency and instance numbering.
    issue(3'b010, 1'b0, {VLEN{8'd50}}, {VLEN{8'd25}}, 8'd0);
    chk("t1_en_beat0", alu_en, 1'b1);
    chk("t1_idx_beat0", alu_instance_num, {3'd3, 3'd2, 3'd1, 3'd0});
    tick();
    chk("t1_idx_beat1", alu_instance_num, {3'd7, 3'd6, 3'd5, 3'd4});
    chk("t1_valid_early", out_valid, 1'b0);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_vec", out_vec, {VLEN{8'd75}});
    chk("t1_flags", out_flags, 4'b0000);
    chk("t1_err", out_err, 1'b0);
    handshake();
    chk("t1_ready_after", in_ready, 1'b1);

    // Signed overflow in element 5 only.
    va = {VLEN{8'd1}}; vb = {VLEN{8'd1}}; ve = {VLEN{8'd2}};
    va[5*WIDTH +: WIDTH] = 8'd100; vb[5*WIDTH +: WIDTH] = 8'd50; ve[5*WIDTH +: WIDTH] = 8'h96;
    issue(3'b010, 1'b0, va, vb, 8'd0);
    tick(); tick();
    chk("t2_vec", out_vec, ve);
    chk("t2_flags", out_flags, 4'b1100);
    handshake();

    // Set broadcasts c = -50.
    issue(3'b111, 1'b0, rand_vec(), rand_vec(), 8'hCE);
    chk("t3_alu_c_beat0", alu_c, {LANES{8'hCE}});
    tick();
    chk("t3_alu_c_beat1", alu_c, {LANES{8'hCE}});
    tick();
    chk("t3_vec", out_vec, {VLEN{8'hCE}});
    chk("t3_flags", out_flags, 4'b0100);
    handshake();

    // Back-pressure with a pending request.
    issue(3'b010, 1'b0, {VLEN{8'd50}}, {VLEN{8'd25}}, 8'd0);
    tick(); tick();
    in_valid = 1'b1; in_vec_a = {VLEN{8'd50}}; in_vec_b = {VLEN{8'd25}};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_vec", out_vec, {VLEN{8'd75}});
      chk("t4_hold_flags", out_flags, 4'b0000);
      chk("t4_hold_ready", in_ready, 1'b0);
    end
    handshake();
    chk("t4_no_reaccept", alu_en, 1'b0);
    chk("t4_ready_up", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t4_accepted", alu_en, 1'b1);
    tick(); tick();
    chk("t4_second_vec", out_vec, {VLEN{8'd75}});
    handshake();

    // Illegal opcode.
    issue(3'b100, 1'b0, rand_vec(), rand_vec(), 8'd3);
    chk("t5_en", alu_en, 1'b0);
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_err", out_err, 1'b1);
    chk("t5_vec", out_vec, '0);
    handshake();

    // Abort during beat 0.
    issue(3'b010, 1'b0, rand_vec(), rand_vec(), 8'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_valid", out_valid, 1'b0);
    end

    // Reset during beat 0.
    issue(3'b001, 1'b1, rand_vec(), rand_vec(), 8'd9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_ready", in_ready, 1'b1);
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_en", alu_en, 1'b0);
    chk("t7_vec", out_vec, '0);
    chk("t7_flags", out_flags, 4'b0000);
    chk("t7_alu_a", alu_a, '0);
    chk("t7_opcode", alu_opcode, 3'b000);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid       = 1'($urandom_range(0, 1));
      in_opcode      = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 3)] : ops[$urandom_range(4, 7)];
      in_flag_scalar = 1'($urandom_range(0, 1));
      in_vec_a       = rand_vec();
      in_vec_b       = rand_vec();
      in_scalar_c    = WIDTH'($urandom);
      out_ready      = ($urandom_range(0, 2) != 0);
      abort          = ($urandom_range(0, 29) == 0);
      rst_n          = ($urandom_range(0, 99) != 0);
      tick();
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
